input_delay_skew_capture: RTL and testbench

Input capture stage fed directly by the top-level ports `port1`/`port2` of the input-delay timing benchmark. It registers both ports on `src_clk`, detects rising edges, counts `port1` rising edges, and measures the skew in cycles between a `port1` rising edge and the following `port2` rising edge. Each skew measurement is delivered on a valid/ready output. Every path from `port1`/`port2` ends at a capture flop, so input-delay constraints on these ports remain the only constraints that time the port-to-register paths.

---
 rtl/input_delay_skew_capture_if.sv | 46 ++++
 rtl/input_delay_skew_capture.sv | 141 ++++++++++++++
 tb/tb_input_delay_skew_capture.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_delay_skew_capture_if.sv
// Port bundle for the input-delay skew capture stage: raw timed inputs, control and the
// valid/ready skew result channel.
interface input_delay_skew_capture_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             port1;
  logic             port2;
  logic             capture_en;
  logic             out;
  logic [CNT_W-1:0] rise_cnt;
  logic             overflow;
  logic [CNT_W-1:0] skew;
  logic             skew_valid;
  logic             skew_ready;
  logic             timeout;

  // Environment side: drives the ports and consumes the measurement.
  modport master (
    output port1,
    output port2,
    output capture_en,
    output skew_ready,
    input  out,
    input  rise_cnt,
    input  overflow,
    input  skew,
    input  skew_valid,
    input  timeout
  );

  // Capture stage side.
  modport slave (
    input  port1,
    input  port2,
    input  capture_en,
    input  skew_ready,
    output out,
    output rise_cnt,
    output overflow,
    output skew,
    output skew_valid,
    output timeout
  );

endinterface

// File: rtl/input_delay_skew_capture.sv
// Registers port1/port2 on src_clk, counts port1 rises and measures the cycle skew from a
// port1 rise to the following port2 rise, delivering each result on a valid/ready channel.
module input_delay_skew_capture #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_SKEW = 15
) (
  input logic                         src_clk,
  input logic                         rst,
  input_delay_skew_capture_if.slave   bus
);

  localparam logic [CNT_W-1:0] MaxSkewCnt = CNT_W'(MAX_SKEW);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StWait,
    StHold
  } state_e;

  logic             p1_q, p2_q;
  logic             p1_d, p2_d;
  logic             out_q;
  logic             r1, r2;
  logic [CNT_W-1:0] rise_cnt_q;
  logic             overflow_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] skew_cnt_q, skew_cnt_d;
  logic [CNT_W-1:0] skew_q, skew_d;
  logic             timeout_q, timeout_d;

  logic             capture_en;
  logic             skew_ready;

  assign capture_en = bus.capture_en;
  assign skew_ready = bus.skew_ready;

  // The ports feed nothing but these first-stage flops, so only input-delay constraints time them.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      p1_q  <= 1'b0;
      p2_q  <= 1'b0;
      p1_d  <= 1'b0;
      p2_d  <= 1'b0;
      out_q <= 1'b0;
    end else begin
      p1_q  <= bus.port1;
      p2_q  <= bus.port2;
      p1_d  <= p1_q;
      p2_d  <= p2_q;
      out_q <= p1_q | p2_q;
    end
  end

  assign r1 = p1_q & ~p1_d;
  assign r2 = p2_q & ~p2_d;

  always_ff @(posedge src_clk) begin
    if (rst) begin
      rise_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (capture_en && r1) begin
      if (&rise_cnt_q) begin
        overflow_q <= 1'b1;
      end else begin
        rise_cnt_q <= rise_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      skew_cnt_q <= '0;
      skew_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      skew_cnt_q <= skew_cnt_d;
      skew_q     <= skew_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    skew_cnt_d = skew_cnt_q;
    skew_d     = skew_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture_en) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (!capture_en) begin
          state_d = StIdle;
        end else if (r1 && r2) begin
          state_d = StHold;
          skew_d  = '0;
        end else if (r1) begin
          state_d    = StWait;
          skew_cnt_d = CntOne;
        end
      end
      StWait: begin
        // A port2 rise on the final counted cycle takes priority over the timeout.
        if (!capture_en) begin
          state_d = StIdle;
        end else if (r2) begin
          state_d = StHold;
          skew_d  = skew_cnt_q;
        end else if (skew_cnt_q == MaxSkewCnt) begin
          state_d   = StArmed;
          timeout_d = 1'b1;
        end else begin
          skew_cnt_d = skew_cnt_q + CntOne;
        end
      end
      StHold: begin
        if (skew_ready) begin
          state_d = capture_en ? StArmed : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.out        = out_q;
  assign bus.rise_cnt   = rise_cnt_q;
  assign bus.overflow   = overflow_q;
  assign bus.skew       = skew_q;
  assign bus.skew_valid = (state_q == StHold);
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_input_delay_skew_capture.sv
// Directed bench for input_delay_skew_capture with CNT_W=4, MAX_SKEW=15; expected values are
// hand-computed from the edge-by-edge behaviour of the capture stage.
module tb_input_delay_skew_capture;

  localparam int unsigned CntW    = 4;
  localparam int unsigned MaxSkew = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  input_delay_skew_capture_if #(.CNT_W(CntW)) bus ();

  input_delay_skew_capture #(
    .CNT_W   (CntW),
    .MAX_SKEW(MaxSkew)
  ) dut (
    .src_clk(clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ports_low();
    bus.port1 = 1'b0;
    bus.port2 = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.port1 = 1'b1;
    bus.port2 = 1'b1;
    bus.capture_en = 1'b0;
    bus.skew_ready = 1'b0;
    tick(3);
    checks++;
    if ({bus.out, bus.rise_cnt, bus.overflow, bus.skew, bus.skew_valid, bus.timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%b cnt=%0d ovf=%b skew=%0d v=%b to=%b expected all 0",
               bus.out, bus.rise_cnt, bus.overflow, bus.skew, bus.skew_valid, bus.timeout);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (bus.out !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_lat1: got %b expected 0", bus.out);
    end
    tick(1);
    checks++;
    if (bus.out !== 1'b1) begin
      errors++;
      $display("FAIL reset_out_lat2: got %b expected 1", bus.out);
    end
    ports_low();
  endtask

  task automatic test_skew();
    bus.capture_en = 1'b1;
    bus.skew_ready = 1'b1;
    tick(1);
    bus.port1 = 1'b1;
    tick(2);
    checks++;
    if (bus.out !== 1'b1) begin
      errors++;
      $display("FAIL skew_out: got %b expected 1", bus.out);
    end
    tick(2);
    bus.port2 = 1'b1;
    tick(1);
    checks++;
    if (bus.skew_valid !== 1'b0) begin
      errors++;
      $display("FAIL skew_early_valid: got %b expected 0", bus.skew_valid);
    end
    tick(1);
    checks++;
    if (bus.skew_valid !== 1'b1 || bus.skew !== 4'd4) begin
      errors++;
      $display("FAIL skew_value: got v=%b skew=%0d expected v=1 skew=4", bus.skew_valid, bus.skew);
    end
    checks++;
    if (bus.rise_cnt !== 4'd1) begin
      errors++;
      $display("FAIL skew_rise_cnt: got %0d expected 1", bus.rise_cnt);
    end
    tick(1);
    checks++;
    if (bus.skew_valid !== 1'b0) begin
      errors++;
      $display("FAIL skew_one_cycle: got %b expected 0", bus.skew_valid);
    end
    ports_low();
  endtask

  task automatic test_simultaneous();
    bus.skew_ready = 1'b0;
    bus.port1 = 1'b1;
    bus.port2 = 1'b1;
    tick(2);
    checks++;
    if (bus.skew_valid !== 1'b1 || bus.skew !== 4'd0) begin
      errors++;
      $display("FAIL simul_value: got v=%b skew=%0d expected v=1 skew=0", bus.skew_valid, bus.skew);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (bus.skew_valid !== 1'b1 || bus.skew !== 4'd0) begin
        errors++;
        $display("FAIL simul_hold: got v=%b skew=%0d expected v=1 skew=0 at cycle %0d",
                 bus.skew_valid, bus.skew, i);
      end
    end
    bus.skew_ready = 1'b1;
    tick(1);
    checks++;
    if (bus.skew_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_release: got %b expected 0", bus.skew_valid);
    end
    ports_low();
  endtask

  task automatic test_timeout();
    logic seen_bad;
    seen_bad = 1'b0;
    bus.port1 = 1'b1;
    tick(1);
    bus.port1 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (bus.timeout !== 1'b0 || bus.skew_valid !== 1'b0) seen_bad = 1'b1;
    end
    checks++;
    if (seen_bad !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got early pulse/valid expected none");
    end
    tick(1);
    checks++;
    if (bus.timeout !== 1'b1 || bus.skew_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got to=%b v=%b expected to=1 v=0", bus.timeout, bus.skew_valid);
    end
    tick(1);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: got %b expected 0", bus.timeout);
    end
    bus.port1 = 1'b1;
    tick(3);
    bus.port2 = 1'b1;
    tick(2);
    checks++;
    if (bus.skew_valid !== 1'b1 || bus.skew !== 4'd3) begin
      errors++;
      $display("FAIL timeout_after: got v=%b skew=%0d expected v=1 skew=3", bus.skew_valid, bus.skew);
    end
    ports_low();
    bus.port1 = 1'b1;
    tick(15);
    bus.port2 = 1'b1;
    tick(2);
    checks++;
    if (bus.skew_valid !== 1'b1 || bus.skew !== 4'd15 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_boundary: got v=%b skew=%0d to=%b expected v=1 skew=15 to=0",
               bus.skew_valid, bus.skew, bus.timeout);
    end
    ports_low();
  endtask

  task automatic test_abort();
    logic seen_valid;
    seen_valid = 1'b0;
    bus.port1 = 1'b1;
    tick(2);
    bus.capture_en = 1'b0;
    tick(1);
    bus.port2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus.skew_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_valid: got valid expected none");
    end
    checks++;
    if (bus.rise_cnt !== 4'd6) begin
      errors++;
      $display("FAIL abort_rise_cnt: got %0d expected 6", bus.rise_cnt);
    end
    bus.capture_en = 1'b1;
    ports_low();
  endtask

  task automatic test_reset_in_hold();
    bus.skew_ready = 1'b0;
    bus.port1 = 1'b1;
    bus.port2 = 1'b1;
    tick(2);
    checks++;
    if (bus.skew_valid !== 1'b1 || bus.rise_cnt !== 4'd7) begin
      errors++;
      $display("FAIL hold_before_rst: got v=%b cnt=%0d expected v=1 cnt=7",
               bus.skew_valid, bus.rise_cnt);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (bus.skew_valid !== 1'b0 || bus.rise_cnt !== 4'd0) begin
      errors++;
      $display("FAIL hold_rst: got v=%b cnt=%0d expected v=0 cnt=0", bus.skew_valid, bus.rise_cnt);
    end
    bus.skew_ready = 1'b1;
    ports_low();
  endtask

  task automatic pulse_port1(input int n);
    for (int i = 0; i < n; i++) begin
      bus.port1 = 1'b1;
      tick(1);
      bus.port1 = 1'b0;
      tick(1);
    end
  endtask

  task automatic test_saturation();
    bus.capture_en = 1'b1;
    pulse_port1(15);
    checks++;
    if (bus.rise_cnt !== 4'd15 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_full: got cnt=%0d ovf=%b expected cnt=15 ovf=0", bus.rise_cnt, bus.overflow);
    end
    pulse_port1(2);
    checks++;
    if (bus.rise_cnt !== 4'd15 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_over: got cnt=%0d ovf=%b expected cnt=15 ovf=1", bus.rise_cnt, bus.overflow);
    end
    bus.capture_en = 1'b0;
    pulse_port1(3);
    checks++;
    if (bus.rise_cnt !== 4'd15 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_disabled: got cnt=%0d ovf=%b expected cnt=15 ovf=1",
               bus.rise_cnt, bus.overflow);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.port1 = 1'b0;
    bus.port2 = 1'b0;
    bus.capture_en = 1'b0;
    bus.skew_ready = 1'b0;
    test_reset();
    test_skew();
    test_simultaneous();
    test_timeout();
    test_abort();
    test_reset_in_hold();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
